window_gen_3x3: RTL and testbench
=================================

Name: window_gen_3x3

Overview:
- Upstream neighbour of the 3x3 convolution stage.
- Accepts a raster-order pixel stream (one pixel per valid_in cycle, runtime width/height).
- Emits one zero-padded 3x3 neighbourhood per input pixel, so the conv stage produces exactly img_width*img_height results.
- Holds two lines in internal line buffers and self-generates the bottom-edge flush after valid_in drops.

Parameters:
- DATA_WIDTH, 16, signed pixel width.
- MAX_W, 256, line-buffer depth; maximum supported img_width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  pixel_in valid this cycle; no backpressure.
- pixel_in  in  DATA_WIDTH  signed pixel.
- img_width  in  8  frame width; sampled on first accepted pixel.
- img_height  in  8  frame height; sampled on first accepted pixel.
- valid_out  out  1  win_out valid, one cycle per window.
- win_out  out  9*DATA_WIDTH  window; tap k at [k*DATA_WIDTH +: DATA_WIDTH], k=row*3+col, tap 0 top-left, tap 4 centre.
- frame_done  out  1  one-cycle pulse with the last window of a frame.
- busy  out  1  high from first accepted pixel through frame_done.
- overrun  out  1  sticky: valid_in seen while FLUSH.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0, state IDLE, counters 0. Line-buffer contents don't care. Reset mid-frame aborts the frame with no further output.
- States:
  - IDLE -> FILL on valid_in; latch W, H.
  - FILL: first W+1 pixels; no output.
  - STREAM: each accepted pixel emits one window.
  - FLUSH: after pixel W*H-1, W+1 self-timed cycles, one per clock, inject zeros and emit the remaining windows.
  - FLUSH -> IDLE on the cycle frame_done is asserted.
- Config check: if W<3, W>MAX_W or H<3 at start, the frame is rejected: stay IDLE, no windows. Pixels are dropped until valid_in is low for one cycle.
- Latency: window centred at (r,c) is registered in the cycle after pixel index r*W+c+W+1 is accepted, or after the equivalent flush cycle. valid_out is high for exactly one cycle per window. Windows appear in raster order; exactly W*H per frame.
- Gaps in valid_in during FILL/STREAM stall the pipeline; no windows are emitted on idle cycles.
- Padding: taps outside the frame are 0. Row -1 and row H are handled by the row counter; column -1 and column W by the column counter. Line-buffer reads are never used for padded taps, so no wrap across rows.
- Line buffers: two MAX_W x DATA_WIDTH memories, indexed by input column. Each is written and read at the same address in one cycle with read-before-write.
- Shift registers: a 3x3 register window shifts left each advance. Values pass through unmodified; no arithmetic, no width change.
- valid_in during FLUSH: pixel dropped and overrun set; overrun clears only on reset. A new frame is accepted from IDLE, including the cycle after frame_done.
- frame_done coincides with valid_out of the window centred at (H-1, W-1).

Optional Feature:
- Macro: WIN_REPLICATE_PAD_EN.
- Defined: out-of-frame taps take the nearest in-frame pixel (edge replication, clamped row/col) instead of 0.
- Undefined: zero padding as above.
- Timing, counts and ports are identical in both builds.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_WIDTH default.
  - Window tap index constants TAP_TL..TAP_BR (0..8).
  - State encoding IDLE/FILL/STREAM/FLUSH.
  - Frame-size limit constants shared with the conv/pool stages.
- One sub-module: line_buffer, a single-port read-before-write RAM of MAX_W x DATA_WIDTH, instantiated twice.

Test Plan:
- 8x8 frame, row 0 = 123,45,67,89,210,32,99,150 and row 1 = 34,255,128,0,98,76,120,180. First valid_out comes one cycle after the 10th accepted pixel, with win_out taps = 0,0,0,0,123,45,0,34,255.
- Same frame, last window (centre (7,7)=150, (6,6)=170, (6,7)=210, (7,6)=130): taps = 170,210,0,130,150,0,0,0,0. frame_done high the same cycle; 64 valid_out total; busy drops next cycle.
- Same frame fed with valid_in toggling 1/0 every cycle: identical 64 windows in the same order; no valid_out while FILL lacks a new pixel.
- img_width=2, img_height=8, 16 pixels: zero valid_out and busy stays 0. A following valid 4x4 frame then yields 16 windows.
- valid_in held high 3 cycles into FLUSH of a 4x4 frame: overrun=1, still exactly 16 windows. Reset then clears overrun to 0.
- rst_n pulsed low mid-STREAM: valid_out and busy go 0 immediately (asynchronous). A fresh 3x3 frame then gives 9 windows; centre-(1,1) window equals the 9 input pixels in order.
- With WIN_REPLICATE_PAD_EN, 8x8 first window: taps = 123,123,45,123,123,45,34,34,255.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN pixel-pipeline stages
// (window generator, conv, pool).
//   - default pixel width
//   - 3x3 window tap indices (row*3 + col, tap 0 top-left)
//   - window generator state encoding
//   - frame-size limits
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 16;

  // Frame-size limits shared by all stages.
  localparam int CNN_MIN_DIM = 3;
  localparam int CNN_MAX_W   = 256;
  localparam int CNN_MAX_H   = 255;

  // Tap indices within a 3x3 window.
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } win_state_e;

endpackage

// File: rtl/line_buffer.sv
// line_buffer: single-port RAM of DEPTH x DATA_WIDTH with read-before-write.
// The read is combinational from the addressed entry, so in a cycle where
// we=1 the old contents appear on rdata while wdata is stored at the edge.
// Contents are not reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   addr   in   read/write address
//   wdata  in   write data
//   rdata  out  contents of addr before this cycle's write
module line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int AW         = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: turns a raster pixel stream into one padded 3x3
// neighbourhood per input pixel. Two line buffers hold the previous two
// rows. After the last pixel, W+1 self-timed cycles inject zeros to flush
// the bottom row of windows.
// Build option: WIN_REPLICATE_PAD_EN -- out-of-frame taps copy the nearest
// in-frame pixel instead of being zero.
// Ports:
//   clk, rst_n           clock (rising), async active-low reset
//   valid_in, pixel_in   input pixel stream, no backpressure
//   img_width/height     frame size, sampled on the first accepted pixel
//   valid_out, win_out   window strobe and 9 taps (tap k = row*3+col)
//   frame_done           pulse with the last window of a frame
//   busy                 frame in progress, through frame_done
//   overrun              sticky: pixel offered during the flush
module window_gen_3x3
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int MAX_W      = CNN_MAX_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   pixel_in,
  input  logic [7:0]              img_width,
  input  logic [7:0]              img_height,
  output logic                    valid_out,
  output logic [9*DATA_WIDTH-1:0] win_out,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  win_state_e state_q, state_d;
  logic [7:0] w_q, w_d, h_q, h_d, col_q, col_d;
  logic [8:0] row_q, row_d;
  logic [2:0][DATA_WIDTH-1:0] col_a_q, col_a_d, col_b_q, col_b_d, col_x;
  logic drop_q, drop_d, valid_q, valid_d, fd_q, fd_d, busy_q, busy_d;
  logic ovr_q, ovr_d;
  logic [9*DATA_WIDTH-1:0] win_q, win_d;

  logic [DATA_WIDTH-1:0] pix, lb0_rd, lb1_rd;
  logic [AW-1:0] lb_addr;
  logic cfg_ok, accept_new, adv, emit;
  logic [8:0] wr;
  logic [7:0] wc;
  logic top_ok, bot_ok, left_ok, right_ok;
  logic [DATA_WIDTH-1:0] tap [3][3];

  // lb0 holds the previous row, lb1 the row before it; lb1 is refilled from
  // lb0's old contents so both shift down one row per input row.
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_W), .AW(AW)) u_lb0 (
    .clk(clk), .we(adv), .addr(lb_addr), .wdata(pix), .rdata(lb0_rd)
  );

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_W), .AW(AW)) u_lb1 (
    .clk(clk), .we(adv), .addr(lb_addr), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_comb begin
    cfg_ok = (img_width >= 8'(CNN_MIN_DIM)) && ({24'd0, img_width} <= 32'(MAX_W)) &&
             (img_height >= 8'(CNN_MIN_DIM));
    accept_new = (state_q == IDLE) && valid_in && !drop_q && cfg_ok;
    adv = accept_new || (((state_q == FILL) || (state_q == STREAM)) && valid_in) ||
          (state_q == FLUSH);
    pix = (state_q == FLUSH) ? '0 : pixel_in;
    lb_addr = accept_new ? '0 : col_q[AW-1:0];

    // Incoming column: rows (cur-2, cur-1, cur) at the current input column.
    col_x[0] = lb1_rd;
    col_x[1] = lb0_rd;
    col_x[2] = pix;

    // Input at (row,col) completes the window centred at (row-1,col-1); at
    // col 0 it instead completes (row-2,W-1), whose right column is off-frame.
    emit = adv && (state_q != IDLE) &&
           (((col_q != 8'd0) && (row_q != 9'd0)) || ((col_q == 8'd0) && (row_q >= 9'd2)));
    wr = (col_q == 8'd0) ? (row_q - 9'd2) : (row_q - 9'd1);
    wc = (col_q == 8'd0) ? (w_q - 8'd1) : (col_q - 8'd1);
    top_ok   = (wr != 9'd0);
    bot_ok   = (wr != ({1'b0, h_q} - 9'd1));
    left_ok  = (wc != 8'd0);
    right_ok = (wc != (w_q - 8'd1));

    // Left/centre/right are always the two stored columns plus the incoming
    // one; only the padding masks depend on which window is being completed.
    for (int unsigned r = 0; r < 3; r++) begin
      tap[r][0] = col_a_q[r];
      tap[r][1] = col_b_q[r];
      tap[r][2] = col_x[r];
    end
    for (int unsigned c = 0; c < 3; c++) begin
`ifdef WIN_REPLICATE_PAD_EN
      if (!top_ok) tap[0][c] = tap[1][c];
      if (!bot_ok) tap[2][c] = tap[1][c];
`else
      if (!top_ok) tap[0][c] = '0;
      if (!bot_ok) tap[2][c] = '0;
`endif
    end
    for (int unsigned r = 0; r < 3; r++) begin
`ifdef WIN_REPLICATE_PAD_EN
      if (!left_ok)  tap[r][0] = tap[r][1];
      if (!right_ok) tap[r][2] = tap[r][1];
`else
      if (!left_ok)  tap[r][0] = '0;
      if (!right_ok) tap[r][2] = '0;
`endif
    end

    win_d = win_q;
    if (emit) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_d[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = tap[r][c];
        end
      end
    end

    col_a_d = col_a_q;
    col_b_d = col_b_q;
    if (adv) begin
      col_a_d = col_b_q;
      col_b_d = col_x;
    end

    w_d = accept_new ? img_width  : w_q;
    h_d = accept_new ? img_height : h_q;
    col_d = col_q;
    row_d = row_q;
    if (accept_new) begin
      col_d = 8'd1;
      row_d = '0;
    end else if (adv) begin
      if (col_q == (w_q - 8'd1)) begin
        col_d = '0;
        row_d = row_q + 9'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end

    state_d = state_q;
    fd_d = 1'b0;
    unique case (state_q)
      IDLE:   if (accept_new) state_d = FILL;
      FILL:   if (valid_in && (row_q == 9'd1) && (col_q == 8'd0)) state_d = STREAM;
      STREAM: if (valid_in && (row_q == ({1'b0, h_q} - 9'd1)) && (col_q == (w_q - 8'd1)))
                state_d = FLUSH;
      FLUSH:  if ((row_q == ({1'b0, h_q} + 9'd1)) && (col_q == 8'd0)) begin
                state_d = IDLE;
                fd_d = 1'b1;
              end
      default: state_d = IDLE;
    endcase

    drop_d  = drop_q ? valid_in : ((state_q == IDLE) && valid_in && !cfg_ok);
    valid_d = emit;
    busy_d  = (state_d != IDLE) || fd_d;
    ovr_d   = ovr_q || ((state_q == FLUSH) && valid_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      col_a_q <= '0;
      col_b_q <= '0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      row_q   <= row_d;
      col_a_q <= col_a_d;
      col_b_q <= col_b_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      win_q   <= win_d;
    end
  end

  assign valid_out  = valid_q;
  assign win_out    = win_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid_in = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic [7:0] img_width = 8'd8;
  logic [7:0] img_height = 8'd8;
  logic valid_out;
  logic [9*DW-1:0] win_out;
  logic frame_done, busy, overrun;

  window_gen_3x3 #(.DATA_WIDTH(DW), .MAX_W(256)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pixel_in(pixel_in),
    .img_width(img_width), .img_height(img_height), .valid_out(valid_out),
    .win_out(win_out), .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [9*DW-1:0] win;
    logic            fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [DW-1:0] img [0:4095];
  logic [9*DW-1:0] got_win [0:4095];
  int n_got = 0;
  int base = 0;
  bit busy_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input logic [9*DW-1:0] act,
                         input logic [9*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference pixel lookup with frame-edge padding.
  function automatic logic [DW-1:0] px(input int r, input int c, input int w, input int h);
`ifdef WIN_REPLICATE_PAD_EN
    if (r < 0) r = 0;
    if (r >= h) r = h - 1;
    if (c < 0) c = 0;
    if (c >= w) c = w - 1;
`else
    if (r < 0 || r >= h || c < 0 || c >= w) return '0;
`endif
    return img[r*w + c];
  endfunction

  task automatic push_frame(input int w, input int h);
    exp_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e.win = '0;
        for (int k = 0; k < 9; k++) e.win[k*DW +: DW] = px(r + k/3 - 1, c + k%3 - 1, w, h);
        e.fd = (r == h-1) && (c == w-1);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic [9*DW-1:0] pack9(input int t [9]);
    logic [9*DW-1:0] v;
    for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(t[k]);
    return v;
  endfunction

  // Monitor: every presented window is popped from the scoreboard and compared.
  always begin
    @(posedge clk);
    #1;
    if (busy) busy_seen = 1;
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_window: got %h expected none", win_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk_win("window", win_out, mon_e.win);
        chk("frame_done_flag", frame_done, mon_e.fd);
      end
      if (n_got < 4096) got_win[n_got] = win_out;
      n_got++;
    end else if (frame_done) begin
      chk("frame_done_without_valid", frame_done, 0);
    end
  end

  task automatic feed(input int w, input int h, input int n, input bit toggle,
                      input int extra, input bit chk_first);
    int fe [9];
`ifdef WIN_REPLICATE_PAD_EN
    fe = '{123, 123, 45, 123, 123, 45, 34, 34, 255};
`else
    fe = '{0, 0, 0, 0, 123, 45, 0, 34, 255};
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      pixel_in = img[i];
      if (i == 0) begin
        img_width = 8'(w);
        img_height = 8'(h);
      end else if (chk_first) begin
        img_width = 8'($urandom);
        img_height = 8'($urandom);
      end
      if (chk_first && (i == 8 || i == 9)) begin
        @(posedge clk);
        #2;
        chk("windows_after_fill", n_got - base, i - 8);
        if (i == 9) begin
          chk("first_valid_out", valid_out, 1);
          chk_win("first_window", win_out, pack9(fe));
        end
      end
      if (toggle) begin
        @(negedge clk);
        valid_in = 1'b0;
      end
    end
    for (int j = 0; j < extra; j++) begin
      @(negedge clk);
      valid_in = 1'b1;
      pixel_in = DW'($urandom);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain(input string name, input int expect_n);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_count"}, n_got - base, expect_n);
  endtask

  task automatic rand_img(input int n);
    for (int i = 0; i < n; i++) img[i] = DW'($urandom);
  endtask

  task automatic load_8x8();
    int r0 [8] = '{123, 45, 67, 89, 210, 32, 99, 150};
    int r1 [8] = '{34, 255, 128, 0, 98, 76, 120, 180};
    rand_img(64);
    for (int c = 0; c < 8; c++) begin
      img[c] = DW'(r0[c]);
      img[8 + c] = DW'(r1[c]);
    end
    img[6*8 + 6] = DW'(170);
    img[6*8 + 7] = DW'(210);
    img[7*8 + 6] = DW'(130);
    img[7*8 + 7] = DW'(150);
  endtask

  initial begin
    int le [9];
    bit got_fd;
`ifdef WIN_REPLICATE_PAD_EN
    le = '{170, 210, 210, 130, 150, 150, 130, 150, 150};
`else
    le = '{170, 210, 0, 130, 150, 0, 0, 0, 0};
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid_out", valid_out, 0);
    chk("reset_win_out_zero", (win_out == '0), 1);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    // 8x8 frame, continuous stream
    load_8x8();
    base = n_got;
    push_frame(8, 8);
    feed(8, 8, 64, 1'b0, 0, 1'b1);
    got_fd = 0;
    for (int i = 0; i < 300 && !got_fd; i++) begin
      @(posedge clk);
      #2;
      if (frame_done) got_fd = 1;
    end
    chk("frame_done_seen", got_fd, 1);
    chk("busy_with_frame_done", busy, 1);
    @(posedge clk);
    #2;
    chk("busy_after_frame_done", busy, 0);
    chk("frame8_queue_empty", exp_q.size(), 0);
    chk("frame8_count", n_got - base, 64);
    chk_win("last_window", got_win[base + 63], pack9(le));

    // same frame with valid_in toggling every cycle
    repeat (3) @(negedge clk);
    base = n_got;
    push_frame(8, 8);
    feed(8, 8, 64, 1'b1, 0, 1'b0);
    drain("toggle8", 64);

    // rejected frame (width 2), then a valid 4x4 frame
    busy_seen = 0;
    base = n_got;
    rand_img(16);
    feed(2, 8, 16, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("reject_busy_never", busy_seen, 0);
    chk("reject_no_windows", n_got - base, 0);
    rand_img(16);
    push_frame(4, 4);
    feed(4, 4, 16, 1'b0, 0, 1'b0);
    drain("after_reject4", 16);

    // valid_in held three cycles into the flush
    base = n_got;
    rand_img(16);
    push_frame(4, 4);
    feed(4, 4, 16, 1'b0, 3, 1'b0);
    drain("overrun4", 16);
    chk("overrun_set", overrun, 1);

    // reset pulsed mid-stream
    base = n_got;
    rand_img(64);
    push_frame(8, 8);
    feed(8, 8, 30, 1'b0, 0, 1'b0);
    chk("valid_before_reset", valid_out, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_valid_out", valid_out, 0);
    chk("reset_mid_busy", busy, 0);
    chk("reset_clears_overrun", overrun, 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("no_output_after_abort", n_got - base, 30 - 9);

    // fresh 3x3 frame
    base = n_got;
    rand_img(9);
    push_frame(3, 3);
    feed(3, 3, 9, 1'b0, 0, 1'b0);
    drain("frame3", 9);
    for (int k = 0; k < 9; k++)
      chk("centre_window_tap", got_win[base + 4][k*DW +: DW], img[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
